board_renderer: RTL and testbench
=================================

# board_renderer

Pixel-pipeline renderer that reads the 4x4 board of tile exponents held by the game state machine and turns the display controller's `hCount`/`vCount`/`bright` scan position into 12-bit `rgb`. It is the read-side consumer of the board store, while the state machine is the writer. It sits between `display_controller` and the `vgaR`/`vgaG`/`vgaB` pins. Sync outputs are delayed alongside `rgb` so pixel colour and sync stay aligned at the connector.

## Interface
Parameters:
- `BOARD_X`, default 236: `hCount` of the board's left edge, including the leading gap.
- `BOARD_Y`, default 47: `vCount` of the board's top edge, including the leading gap.
- `PITCH`, default 112: cell pitch in pixels (gap plus tile).
- `GAP`, default 8: gap in pixels, at the left/top of each cell plus one trailing gap.

Ports:
- `Clk` in 1: pixel-pipeline clock. One clock; reset is asynchronous and active-high.
- `Reset` in 1: asynchronous, active-high reset.
- `hCount` in 10: horizontal scan position.
- `vCount` in 10: vertical scan position.
- `bright` in 1: visible-region flag.
- `hSync_in` in 1: raw horizontal sync from the display controller.
- `vSync_in` in 1: raw vertical sync from the display controller.
- `cell_addr` out 4: board read address `{row[1:0], col[1:0]}`, registered.
- `cell_val` in 4: exponent at `cell_addr`, combinational read. 0 = empty, n = tile value 2^n.
- `rgb` out 12: pixel colour as `{R,G,B}`, 4 bits each.
- `hSync_out` out 1: `hSync_in` delayed to align with `rgb`.
- `vSync_out` out 1: `vSync_in` delayed to align with `rgb`.

## Operation
- Board extent is `W = GAP + 4*PITCH` (456 px) in both axes.
- Inside-board test compares before subtracting: `hCount >= BOARD_X && hCount < BOARD_X+W`. No unsigned underflow is permitted.
- Local offset `lx = hCount - BOARD_X`; `ly` is derived the same way from `vCount`.
- Column `col` is the number of boundaries `112, 224, 336, 448` that `lx` is greater than or equal to.
- `col = 4`, meaning `lx` falls in 448..455, is the trailing gap. The same rule gives `row` from `ly`.
- Cell-local offset `ox = lx - col*PITCH`; `oy` is derived the same way.
- Tile pixel condition: `col<4 && row<4 && ox>=GAP && oy>=GAP`. Any other inside-board pixel is gap.
- Colour priority, first match wins:
  - `!bright` → 12'h000.
  - Outside board → 12'hFFE.
  - Gap → 12'hBAA.
  - Tile → colour from the exponent table below.
- Exponent colour table:
  - 0 → CCB; 1 → EED; 2 → EEC; 3 → FB7; 4 → F96; 5 → F75; 6 → F53.
  - 7 → EC7; 8 → EC6; 9 → EC5; 10 → EC3; 11 → EC2.
  - 12–15 → 333.
- Pipeline stages:
  - S1 registers `in_board`, `is_tile`, `bright`, the syncs, the outline flag, and `cell_addr <= {row,col}`. `cell_addr` holds its previous value on non-tile pixels.
  - S2 registers `cell_val` together with the S1 flags.
  - S3 performs the colour lookup and registers `rgb`, `hSync_out` and `vSync_out`.
- The board may change mid-frame. Each pixel reflects the `cell_val` present during its S2 cycle, and no tearing protection is provided.

## Timing
- Latency: inputs sampled at edge t appear on `rgb`, `hSync_out` and `vSync_out` after edge t+3. Latency is fixed for every pixel.
- The pipeline has no stalls and no handshake. It accepts one pixel per `Clk`, and a repeated `hCount` simply re-renders the same pixel.
- Reset values:
  - `rgb` = 12'h000.
  - `hSync_out` = 1 and `vSync_out` = 1 (inactive).
  - `cell_addr` = 0.
  - All internal stage flags = 0, so they decode as `!bright`.
- Reset asserted mid-line clears all stages immediately. After release, the first valid `rgb` follows 3 edges later, and the intervening outputs are black.
- `cell_val` must settle within the same cycle that `cell_addr` is presented, since the read is combinational.
- Boundary conditions:
  - `hCount = BOARD_X-1` → outside.
  - `BOARD_X` → gap.
  - `BOARD_X+W-1` → gap.
  - `BOARD_X+W` → outside.

## Configuration
- `BOARD_RENDER_OUTLINE_EN` defined:
  - Tile pixels with `ox` or `oy` in `GAP..GAP+1`, or in `PITCH-2..PITCH-1`, belonging to a non-empty cell (`cell_val != 0`) render 12'h776.
  - The outline flag is computed in S1 and qualified in S3.
- Undefined: no outline logic is generated, and tiles are solid colour.
- Latency is 3 cycles in both builds.

## Test plan
- Reset, then release, with `bright=0` → `rgb=000`, `hSync_out=1`, `vSync_out=1`, `cell_addr=0` until 3 edges after the first driven input.
- `bright=1`, `hCount=100`, `vCount=100` → `rgb=FFE` exactly 3 edges later. `hCount=235` → FFE; `hCount=236`, `vCount=60` → BAA.
- `hCount=244`, `vCount=55`, `cell_val=0` → `cell_addr=0`, `rgb=CCB`. The same pixel with `cell_val=11` → `rgb=EC2`.
- `hCount=356`, `vCount=167` → `cell_addr=5`; `cell_val=3` → `rgb=FB7`. `hCount=691` → gap BAA (`col=4`).
- Toggle `hSync_in` as a single-cycle low pulse → `hSync_out` shows an identical pulse delayed by 3 edges. Assert `Reset` mid-pulse → outputs go to reset values asynchronously.
- With `BOARD_RENDER_OUTLINE_EN`: `hCount=244`, `vCount=100`, `cell_val=2` → 776. The same pixel with `cell_val=0` → CCB. Without the macro → EEC.

Source files
------------

// File: rtl/board_renderer.sv
// ---------------------------------------------------------------------------
// board_renderer
// Three-stage pixel pipeline. It turns the display scan position into the
// 12-bit colour of the 4x4 tile board and reads tile exponents from the
// board store through a registered address.
//
// Optional feature macro: BOARD_RENDER_OUTLINE_EN
//   When this macro is defined, a 2-pixel outline (12'h776) is drawn inside
//   each non-empty tile. When it is undefined, tiles are solid colour and no
//   outline logic exists.
//
// Ports:
//   Clk        in   pixel clock
//   Reset      in   asynchronous active-high reset
//   hCount     in   [9:0] horizontal scan position
//   vCount     in   [9:0] vertical scan position
//   bright     in   visible-region flag
//   hSync_in   in   raw horizontal sync
//   vSync_in   in   raw vertical sync
//   cell_addr  out  [3:0] board read address {row,col}, registered
//   cell_val   in   [3:0] exponent at cell_addr (combinational read)
//   rgb        out  [11:0] pixel colour {R,G,B}
//   hSync_out  out  hSync_in aligned with rgb
//   vSync_out  out  vSync_in aligned with rgb
// ---------------------------------------------------------------------------
module board_renderer #(
   parameter int BOARD_X = 236,
   parameter int BOARD_Y = 47,
   parameter int PITCH   = 112,
   parameter int GAP     = 8
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [9:0]  hCount,
   input  logic [9:0]  vCount,
   input  logic        bright,
   input  logic        hSync_in,
   input  logic        vSync_in,
   output logic [3:0]  cell_addr,
   input  logic [3:0]  cell_val,
   output logic [11:0] rgb,
   output logic        hSync_out,
   output logic        vSync_out
);

   localparam int BOARD_W = GAP + 4 * PITCH;

   localparam logic [9:0] X_LO  = 10'(BOARD_X);
   localparam logic [9:0] X_HI  = 10'(BOARD_X + BOARD_W);
   localparam logic [9:0] Y_LO  = 10'(BOARD_Y);
   localparam logic [9:0] Y_HI  = 10'(BOARD_Y + BOARD_W);
   localparam logic [9:0] P1    = 10'(PITCH);
   localparam logic [9:0] P2    = 10'(2 * PITCH);
   localparam logic [9:0] P3    = 10'(3 * PITCH);
   localparam logic [9:0] P4    = 10'(4 * PITCH);
   localparam logic [9:0] GAP_V = 10'(GAP);

   // Count of cell boundaries at or below a board-local offset (0..4).
   function automatic logic [2:0] cellIndex(input logic [9:0] loc);
      cellIndex = {2'b00, (loc >= P1)} + {2'b00, (loc >= P2)}
                + {2'b00, (loc >= P3)} + {2'b00, (loc >= P4)};
   endfunction

   // Offset within the cell selected by idx.
   function automatic logic [9:0] cellOffset(input logic [9:0] loc, input logic [2:0] idx);
      case (idx)
         3'd0:    cellOffset = loc;
         3'd1:    cellOffset = loc - P1;
         3'd2:    cellOffset = loc - P2;
         3'd3:    cellOffset = loc - P3;
         default: cellOffset = loc - P4;
      endcase
   endfunction

`ifdef BOARD_RENDER_OUTLINE_EN
   // True on the two innermost rows/columns at either side of a tile.
   function automatic logic onOutline(input logic [9:0] off);
      onOutline = ((off >= GAP_V) && (off <= GAP_V + 10'd1)) ||
                  ((off >= P1 - 10'd2) && (off <= P1 - 10'd1));
   endfunction
`endif

   // Exponent-to-colour table.
   function automatic logic [11:0] tileColor(input logic [3:0] expo);
      case (expo)
         4'd0:    tileColor = 12'hCCB;
         4'd1:    tileColor = 12'hEED;
         4'd2:    tileColor = 12'hEEC;
         4'd3:    tileColor = 12'hFB7;
         4'd4:    tileColor = 12'hF96;
         4'd5:    tileColor = 12'hF75;
         4'd6:    tileColor = 12'hF53;
         4'd7:    tileColor = 12'hEC7;
         4'd8:    tileColor = 12'hEC6;
         4'd9:    tileColor = 12'hEC5;
         4'd10:   tileColor = 12'hEC3;
         4'd11:   tileColor = 12'hEC2;
         default: tileColor = 12'h333;
      endcase
   endfunction

   // S0 combinational decode
   logic       inX, inY, inBoard, isTile;
   logic [9:0] lx, ly, ox, oy;
   logic [2:0] col, row;

   // S1 / S2 pipeline registers
   logic       s1Bright, s1InBoard, s1Tile, s1HSync, s1VSync;
   logic       s2Bright, s2InBoard, s2Tile, s2HSync, s2VSync;
   logic [3:0] s2Val;
   logic [11:0] nextRgb;
`ifdef BOARD_RENDER_OUTLINE_EN
   logic       isOutline, s1Outline, s2Outline;
`endif

   // Scan-position decode: range test first, then subtract, so no wrap occurs.
   always_comb begin
      inX = (hCount >= X_LO) && (hCount < X_HI);
      inY = (vCount >= Y_LO) && (vCount < Y_HI);
      inBoard = inX && inY;
      if (inX) begin
         lx = hCount - X_LO;
      end else begin
         lx = 10'd0;
      end
      if (inY) begin
         ly = vCount - Y_LO;
      end else begin
         ly = 10'd0;
      end
      col = cellIndex(lx);
      row = cellIndex(ly);
      ox  = cellOffset(lx, col);
      oy  = cellOffset(ly, row);
      // col/row of 4 is the trailing gap strip
      isTile = inBoard && (col < 3'd4) && (row < 3'd4) && (ox >= GAP_V) && (oy >= GAP_V);
`ifdef BOARD_RENDER_OUTLINE_EN
      isOutline = isTile && (onOutline(ox) || onOutline(oy));
`endif
   end

   // S1: register decode results; the read address only moves on tile pixels.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s1Bright  <= 1'b0;
         s1InBoard <= 1'b0;
         s1Tile    <= 1'b0;
         s1HSync   <= 1'b1;
         s1VSync   <= 1'b1;
         cell_addr <= 4'd0;
`ifdef BOARD_RENDER_OUTLINE_EN
         s1Outline <= 1'b0;
`endif
      end else begin
         s1Bright  <= bright;
         s1InBoard <= inBoard;
         s1Tile    <= isTile;
         s1HSync   <= hSync_in;
         s1VSync   <= vSync_in;
         if (isTile) begin
            cell_addr <= {row[1:0], col[1:0]};
         end else begin
            cell_addr <= cell_addr;
         end
`ifdef BOARD_RENDER_OUTLINE_EN
         s1Outline <= isOutline;
`endif
      end
   end

   // S2: capture the board read alongside the S1 flags.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s2Bright  <= 1'b0;
         s2InBoard <= 1'b0;
         s2Tile    <= 1'b0;
         s2HSync   <= 1'b1;
         s2VSync   <= 1'b1;
         s2Val     <= 4'd0;
`ifdef BOARD_RENDER_OUTLINE_EN
         s2Outline <= 1'b0;
`endif
      end else begin
         s2Bright  <= s1Bright;
         s2InBoard <= s1InBoard;
         s2Tile    <= s1Tile;
         s2HSync   <= s1HSync;
         s2VSync   <= s1VSync;
         s2Val     <= cell_val;
`ifdef BOARD_RENDER_OUTLINE_EN
         s2Outline <= s1Outline;
`endif
      end
   end

   // Colour priority: blank, outside, gap, (outline), tile colour.
   always_comb begin
      if (!s2Bright) begin
         nextRgb = 12'h000;
      end else if (!s2InBoard) begin
         nextRgb = 12'hFFE;
      end else if (!s2Tile) begin
         nextRgb = 12'hBAA;
`ifdef BOARD_RENDER_OUTLINE_EN
      end else if (s2Outline && (s2Val != 4'd0)) begin
         nextRgb = 12'h776;
`endif
      end else begin
         nextRgb = tileColor(s2Val);
      end
   end

   // S3: registered outputs.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rgb       <= 12'h000;
         hSync_out <= 1'b1;
         vSync_out <= 1'b1;
      end else begin
         rgb       <= nextRgb;
         hSync_out <= s2HSync;
         vSync_out <= s2VSync;
      end
   end

endmodule

// File: tb/tb_board_renderer.sv
module tb_board_renderer;

   localparam int BX = 236;
   localparam int BY = 47;
   localparam int P  = 112;
   localparam int G  = 8;
   localparam int W  = G + 4 * P;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [9:0]  hCount = 10'd0;
   logic [9:0]  vCount = 10'd0;
   logic        bright = 1'b0;
   logic        hSync_in = 1'b1;
   logic        vSync_in = 1'b1;
   logic [3:0]  cell_addr;
   logic [3:0]  cell_val;
   logic [11:0] rgb;
   logic        hSync_out;
   logic        vSync_out;

   logic [3:0]  board [16];
   logic [11:0] colTbl [16];

   int nCmp = 0;
   int nErr = 0;

   assign cell_val = board[cell_addr];

   board_renderer #(.BOARD_X(BX), .BOARD_Y(BY), .PITCH(P), .GAP(G)) dut (
      .Clk(Clk), .Reset(Reset), .hCount(hCount), .vCount(vCount), .bright(bright),
      .hSync_in(hSync_in), .vSync_in(vSync_in), .cell_addr(cell_addr),
      .cell_val(cell_val), .rgb(rgb), .hSync_out(hSync_out), .vSync_out(vSync_out)
   );

   always #5 Clk = ~Clk;

   // Reference colour from the geometric rules using division/modulo.
   function automatic logic [11:0] refColor(input int h, input int v, input bit b);
      int lx, ly, c, r, ox, oy;
      logic [3:0] e;
      if (!b) return 12'h000;
      if (!(h >= BX && h < BX + W && v >= BY && v < BY + W)) return 12'hFFE;
      lx = h - BX; ly = v - BY;
      c = lx / P; r = ly / P; ox = lx % P; oy = ly % P;
      if (c >= 4 || r >= 4 || ox < G || oy < G) return 12'hBAA;
      e = board[r * 4 + c];
`ifdef BOARD_RENDER_OUTLINE_EN
      if (e != 4'd0 && ((ox >= G && ox <= G + 1) || ox >= P - 2 ||
                        (oy >= G && oy <= G + 1) || oy >= P - 2)) return 12'h776;
`endif
      return colTbl[e];
   endfunction

   task automatic setPx(input int h, input int v, input bit b);
      @(negedge Clk);
      hCount = 10'(h); vCount = 10'(v); bright = b;
   endtask

   task automatic checkRgb(input string name, input logic [11:0] exp);
      nCmp++;
      if (rgb !== exp) begin
         nErr++;
         $display("FAIL %s: rgb=%h expected %h", name, rgb, exp);
      end
   endtask

   task automatic checkAddr(input string name, input logic [3:0] exp);
      nCmp++;
      if (cell_addr !== exp) begin
         nErr++;
         $display("FAIL %s: cell_addr=%0d expected %0d", name, cell_addr, exp);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge Clk);
      #1;
      nCmp++;
      if (rgb !== 12'h000 || hSync_out !== 1'b1 || vSync_out !== 1'b1 || cell_addr !== 4'd0) begin
         nErr++;
         $display("FAIL reset_held: rgb=%h hs=%b vs=%b addr=%0d expected 000 1 1 0",
                  rgb, hSync_out, vSync_out, cell_addr);
      end
      @(negedge Clk);
      Reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         nCmp++;
         if (rgb !== 12'h000 || hSync_out !== 1'b1 || vSync_out !== 1'b1 || cell_addr !== 4'd0) begin
            nErr++;
            $display("FAIL reset_release[%0d]: rgb=%h hs=%b vs=%b addr=%0d expected 000 1 1 0",
                     k, rgb, hSync_out, vSync_out, cell_addr);
         end
      end
   endtask

   task automatic test_latency();
      setPx(100, 100, 1'b1);
      repeat (2) @(posedge Clk);
      #1 checkRgb("latency_2_edges_still_black", 12'h000);
      @(posedge Clk);
      #1 checkRgb("latency_3_edges_outside", 12'hFFE);
   endtask

   task automatic test_boundaries();
      setPx(235, 60, 1'b1);       repeat (3) @(posedge Clk); #1 checkRgb("h_left_minus1", 12'hFFE);
      setPx(236, 60, 1'b1);       repeat (3) @(posedge Clk); #1 checkRgb("h_left_edge", 12'hBAA);
      setPx(BX + W - 1, 60, 1'b1); repeat (3) @(posedge Clk); #1 checkRgb("h_right_edge", 12'hBAA);
      setPx(BX + W, 60, 1'b1);    repeat (3) @(posedge Clk); #1 checkRgb("h_right_plus1", 12'hFFE);
      setPx(300, 46, 1'b1);       repeat (3) @(posedge Clk); #1 checkRgb("v_top_minus1", 12'hFFE);
      setPx(300, 47, 1'b1);       repeat (3) @(posedge Clk); #1 checkRgb("v_top_edge", 12'hBAA);
      setPx(300, 100, 1'b0);      repeat (3) @(posedge Clk); #1 checkRgb("not_bright", 12'h000);
   endtask

   task automatic test_tiles();
      board[0] = 4'd0;
      setPx(244, 55, 1'b1); repeat (3) @(posedge Clk); #1;
      checkAddr("tile00_addr", 4'd0);
      checkRgb("tile00_empty", 12'hCCB);
      board[0] = 4'd11;
      repeat (3) @(posedge Clk); #1 checkRgb("tile00_exp11", 12'hEC2);
      board[5] = 4'd3;
      setPx(356, 167, 1'b1); repeat (3) @(posedge Clk); #1;
      checkAddr("tile11_addr", 4'd5);
      checkRgb("tile11_exp3", 12'hFB7);
      setPx(691, 167, 1'b1); repeat (3) @(posedge Clk); #1;
      checkRgb("trailing_gap", 12'hBAA);
      checkAddr("addr_hold_on_gap", 4'd5);
      board[15] = 4'd14;
      setPx(BX + 3 * P + 50, BY + 3 * P + 50, 1'b1); repeat (3) @(posedge Clk); #1;
      checkAddr("tile33_addr", 4'd15);
      checkRgb("tile33_exp14", 12'h333);
   endtask

   task automatic test_outline();
      board[0] = 4'd2;
      setPx(244, 100, 1'b1); repeat (3) @(posedge Clk); #1;
`ifdef BOARD_RENDER_OUTLINE_EN
      checkRgb("outline_nonempty", 12'h776);
`else
      checkRgb("outline_nonempty", 12'hEEC);
`endif
      board[0] = 4'd0;
      repeat (3) @(posedge Clk); #1 checkRgb("outline_empty", 12'hCCB);
   endtask

   task automatic test_sync_pulse();
      setPx(100, 100, 1'b1);
      hSync_in = 1'b1; vSync_in = 1'b1;
      repeat (4) @(negedge Clk);
      hSync_in = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge Clk);
         hSync_in = 1'b1;
         nCmp++;
         if (hSync_out !== ((k == 3) ? 1'b0 : 1'b1) || vSync_out !== 1'b1) begin
            nErr++;
            $display("FAIL sync_pulse[%0d]: hs=%b vs=%b expected %b 1", k, hSync_out, vSync_out,
                     (k == 3) ? 1'b0 : 1'b1);
         end
      end
   endtask

   task automatic test_reset_mid_pulse();
      board[5] = 4'd3;
      setPx(356, 167, 1'b1);
      hSync_in = 1'b0; vSync_in = 1'b0;
      repeat (4) @(negedge Clk);
      nCmp++;
      if (hSync_out !== 1'b0 || vSync_out !== 1'b0 || rgb !== 12'hFB7 || cell_addr !== 4'd5) begin
         nErr++;
         $display("FAIL pre_reset: hs=%b vs=%b rgb=%h addr=%0d expected 0 0 fb7 5",
                  hSync_out, vSync_out, rgb, cell_addr);
      end
      @(posedge Clk);
      #2 Reset = 1'b1;
      #1;
      nCmp++;
      if (rgb !== 12'h000 || hSync_out !== 1'b1 || vSync_out !== 1'b1 || cell_addr !== 4'd0) begin
         nErr++;
         $display("FAIL async_reset: rgb=%h hs=%b vs=%b addr=%0d expected 000 1 1 0",
                  rgb, hSync_out, vSync_out, cell_addr);
      end
      @(negedge Clk);
      hSync_in = 1'b1; vSync_in = 1'b1; bright = 1'b0;
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_random_stream();
      logic [13:0] expQ [$];
      logic [13:0] e;
      int h, v;
      bit b, hs, vs;
      for (int i = 0; i < 16; i++) board[i] = 4'($urandom_range(0, 15));
      h = 300; v = 200;
      for (int i = 0; i < 603; i++) begin
         @(negedge Clk);
         if (i >= 3) begin
            e = expQ.pop_front();
            nCmp++;
            if ({rgb, hSync_out, vSync_out} !== e) begin
               nErr++;
               $display("FAIL stream[%0d]: rgb/hs/vs=%h/%b/%b expected %h/%b/%b",
                        i - 3, rgb, hSync_out, vSync_out, e[13:2], e[1], e[0]);
            end
         end
         if (i < 600) begin
            if ($urandom_range(0, 7) != 0) begin
               if ($urandom_range(0, 1) == 1) begin
                  h = $urandom_range(220, 710); v = $urandom_range(30, 520);
               end else begin
                  h = $urandom_range(0, 799); v = $urandom_range(0, 524);
               end
            end
            b  = ($urandom_range(0, 9) != 0);
            hs = 1'($urandom_range(0, 1));
            vs = 1'($urandom_range(0, 1));
            hCount = 10'(h); vCount = 10'(v); bright = b;
            hSync_in = hs; vSync_in = vs;
            expQ.push_back({refColor(h, v, b), hs, vs});
         end else begin
            bright = 1'b0; hSync_in = 1'b1; vSync_in = 1'b1;
         end
      end
   endtask

   initial begin
      colTbl = '{12'hCCB, 12'hEED, 12'hEEC, 12'hFB7, 12'hF96, 12'hF75, 12'hF53, 12'hEC7,
                 12'hEC6, 12'hEC5, 12'hEC3, 12'hEC2, 12'h333, 12'h333, 12'h333, 12'h333};
      for (int i = 0; i < 16; i++) board[i] = 4'd0;
      test_reset();
      test_latency();
      test_boundaries();
      test_tiles();
      test_outline();
      test_sync_pulse();
      test_reset_mid_pulse();
      test_random_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
